// File: rtl/bram_dp_param.sv
// Dual-port byte-addressed block RAM: port A read/write (write-first), port B read-only
// (read-first), power-up clear sequencer. Optional output register stage: BRAM_DP_OUTREG_EN.
module bram_dp_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 12
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    output logic                  INIT_BUSY,
    input  logic                  ENA,
    input  logic [DATA_W/8-1:0]   WEA,
    input  logic [ADDR_W-1:0]     AA,
    input  logic [DATA_W-1:0]     DiA,
    output logic [DATA_W-1:0]     DoA,
    output logic                  ERRA,
    input  logic                  ENB,
    input  logic [ADDR_W-1:0]     AB,
    output logic [DATA_W-1:0]     DoB,
    output logic                  ERRB
);

    localparam int BYTES  = DATA_W / 8;
    localparam int OFF_W  = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                 state;
    logic [MEM_AW-1:0]      cnt;
    logic [DATA_W-1:0]      mem [DEPTH];

    logic [IDX_W-1:0]       idx_a;
    logic [IDX_W-1:0]       idx_b;
    logic [MEM_AW-1:0]      word_a;
    logic [MEM_AW-1:0]      word_b;
    logic                   in_a;
    logic                   in_b;
    logic                   ready;
    logic                   wr_a;
    logic [DATA_W-1:0]      merged_a;

    logic [DATA_W-1:0]      doa_p1;
    logic [DATA_W-1:0]      dob_p1;
    logic                   erra_p1;
    logic                   errb_p1;

    // Replace the bytes selected by be with the corresponding bytes of wr.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] wr_word,
        input logic [BYTES-1:0]  be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BYTES; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wr_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Byte-offset bits never select anything; the word index is the address upper part.
    generate
        if (OFF_W > 0) begin : g_off
            logic unused_offset;
            assign unused_offset = ^{AA[OFF_W-1:0], AB[OFF_W-1:0]};
        end
    endgenerate

    assign idx_a  = AA[ADDR_W-1:OFF_W];
    assign idx_b  = AB[ADDR_W-1:OFF_W];
    assign in_a   = 32'(idx_a) < 32'(DEPTH);
    assign in_b   = 32'(idx_b) < 32'(DEPTH);
    assign word_a = idx_a[MEM_AW-1:0];
    assign word_b = idx_b[MEM_AW-1:0];
    assign ready  = (state == READY);

    always_comb begin
        merged_a = byte_merge(mem[word_a], DiA, WEA);
    end

    assign wr_a = RSTN && ready && ENA && in_a && (|WEA);

    // Clear sequencer: one word per cycle, READY at the edge after the last word is zeroed.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= CLEAR;
            cnt       <= '0;
            INIT_BUSY <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST_WORD) begin
                        state     <= READY;
                        cnt       <= '0;
                        INIT_BUSY <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    INIT_BUSY <= 1'b0;
                end
                default: begin
                    state     <= CLEAR;
                    cnt       <= '0;
                    INIT_BUSY <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: the sequencer owns the write port during CLEAR.
    always_ff @(posedge CLK) begin
        if (RSTN && (state == CLEAR)) begin
            mem[cnt] <= '0;
        end else if (wr_a) begin
            mem[word_a] <= merged_a;
        end
    end

    // Stage p1: port A registered read, write-first on its own write.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            doa_p1  <= '0;
            erra_p1 <= 1'b0;
        end else if (ENA) begin
            if (!ready) begin
                doa_p1  <= '0;
                erra_p1 <= 1'b0;
            end else if (!in_a) begin
                doa_p1  <= '0;
                erra_p1 <= 1'b1;
            end else begin
                doa_p1  <= merged_a;
                erra_p1 <= 1'b0;
            end
        end
    end

    // Stage p1: port B registered read, sees the array contents before port A's write.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            dob_p1  <= '0;
            errb_p1 <= 1'b0;
        end else if (ENB) begin
            if (!ready) begin
                dob_p1  <= '0;
                errb_p1 <= 1'b0;
            end else if (!in_b) begin
                dob_p1  <= '0;
                errb_p1 <= 1'b1;
            end else begin
                dob_p1  <= mem[word_b];
                errb_p1 <= 1'b0;
            end
        end
    end

`ifdef BRAM_DP_OUTREG_EN
    logic [DATA_W-1:0] doa_p2;
    logic [DATA_W-1:0] dob_p2;
    logic              erra_p2;
    logic              errb_p2;

    // Stage p2: free-running output register, loads every cycle.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            doa_p2  <= '0;
            dob_p2  <= '0;
            erra_p2 <= 1'b0;
            errb_p2 <= 1'b0;
        end else begin
            doa_p2  <= doa_p1;
            dob_p2  <= dob_p1;
            erra_p2 <= erra_p1;
            errb_p2 <= errb_p1;
        end
    end

    assign DoA  = doa_p2;
    assign DoB  = dob_p2;
    assign ERRA = erra_p2;
    assign ERRB = errb_p2;
`else
    assign DoA  = doa_p1;
    assign DoB  = dob_p1;
    assign ERRA = erra_p1;
    assign ERRB = errb_p1;
`endif

endmodule

// File: tb/tb_bram_dp_param.sv
// Self-checking bench for bram_dp_param: directed steps plus random traffic against
// a word-array model of the memory.
module tb_bram_dp_param;

`ifdef BRAM_DP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        INIT_BUSY;
    logic        ENA = 1'b0;
    logic [3:0]  WEA = 4'h0;
    logic [11:0] AA = 12'h0;
    logic [31:0] DiA = 32'h0;
    logic [31:0] DoA;
    logic        ERRA;
    logic        ENB = 1'b0;
    logic [11:0] AB = 12'h0;
    logic [31:0] DoB;
    logic        ERRB;

    int tests = 0;
    int fails = 0;

    logic [31:0] mm [32];
    logic [31:0] last_a, last_b;
    logic        last_ea, last_eb;

    bram_dp_param #(.DATA_W(32), .DEPTH(32), .ADDR_W(12)) dut (
        .CLK(CLK), .RSTN(RSTN), .INIT_BUSY(INIT_BUSY),
        .ENA(ENA), .WEA(WEA), .AA(AA), .DiA(DiA), .DoA(DoA), .ERRA(ERRA),
        .ENB(ENB), .AB(AB), .DoB(DoB), .ERRB(ERRB)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on each port in the same cycle; results checked after the read latency.
    task automatic op(input logic ena, input logic [3:0] wea, input logic [11:0] aa,
                      input logic [31:0] dia, input logic enb, input logic [11:0] ab,
                      input string tag);
        int ia, ib;
        ia = int'(aa) / 4;
        ib = int'(ab) / 4;
        if (enb) begin
            if (ib >= 32) begin last_b = 32'h0; last_eb = 1'b1; end
            else begin last_b = mm[ib]; last_eb = 1'b0; end
        end
        if (ena) begin
            if (ia >= 32) begin
                last_a = 32'h0; last_ea = 1'b1;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (wea[b]) mm[ia][b*8 +: 8] = dia[b*8 +: 8];
                last_a = mm[ia]; last_ea = 1'b0;
            end
        end
        ENA = ena; WEA = wea; AA = aa; DiA = dia; ENB = enb; AB = ab;
        @(posedge CLK); #1;
        ENA = 1'b0; ENB = 1'b0; WEA = 4'h0;
        repeat (LAT - 1) begin @(posedge CLK); #1; end
        chk($sformatf("%s.DoA", tag), DoA, last_a);
        chk($sformatf("%s.ERRA", tag), 32'(ERRA), 32'(last_ea));
        chk($sformatf("%s.DoB", tag), DoB, last_b);
        chk($sformatf("%s.ERRB", tag), 32'(ERRB), 32'(last_eb));
    endtask

    // Reset, then count INIT_BUSY cycles; an access during CLEAR must be ignored.
    task automatic clear_run(input string tag);
        int n;
        RSTN = 1'b0; ENA = 1'b0; ENB = 1'b0; WEA = 4'h0;
        @(posedge CLK); #1;
        chk($sformatf("%s.rst_busy", tag), 32'(INIT_BUSY), 32'd1);
        chk($sformatf("%s.rst_DoA", tag), DoA, 32'h0);
        chk($sformatf("%s.rst_ERRA", tag), 32'(ERRA), 32'd0);
        chk($sformatf("%s.rst_DoB", tag), DoB, 32'h0);
        chk($sformatf("%s.rst_ERRB", tag), 32'(ERRB), 32'd0);
        RSTN = 1'b1;
        n = 0;
        while (INIT_BUSY === 1'b1 && n < 200) begin
            if (n == 3) begin
                ENA = 1'b1; WEA = 4'hF; AA = 12'h000; DiA = 32'hFFFF_FFFF;
                ENB = 1'b1; AB = 12'h7FC;
            end
            @(posedge CLK); #1;
            n++;
            if (n == 4) begin ENA = 1'b0; ENB = 1'b0; WEA = 4'h0; end
            if (n == 3 + LAT) begin
                chk($sformatf("%s.clr_DoA", tag), DoA, 32'h0);
                chk($sformatf("%s.clr_ERRA", tag), 32'(ERRA), 32'd0);
                chk($sformatf("%s.clr_DoB", tag), DoB, 32'h0);
                chk($sformatf("%s.clr_ERRB", tag), 32'(ERRB), 32'd0);
            end
        end
        chk($sformatf("%s.busy_cycles", tag), 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) mm[i] = 32'h0;
        last_a = 32'h0; last_b = 32'h0; last_ea = 1'b0; last_eb = 1'b0;
    endtask

    initial begin
        logic [31:0] prev_b;
        logic [11:0] ra, rb;

        repeat (2) @(posedge CLK);
        #1;
        clear_run("init");

        for (int i = 0; i < 32; i++)
            op(1'b1, 4'h0, 12'(i * 4 + int'($urandom_range(0, 3))), $urandom,
               1'b1, 12'((31 - i) * 4), $sformatf("zero%0d", i));

        op(1'b1, 4'hF, 12'd12, 32'hDEAD_BEEF, 1'b0, 12'd0, "w3_full");
        op(1'b1, 4'b0010, 12'd13, 32'h0000_1100, 1'b0, 12'd0, "w3_byte");
        chk("w3_byte_const", DoA, 32'hDEAD_11EF);
        op(1'b0, 4'h0, 12'd0, 32'h0, 1'b1, 12'd12, "r3");
        chk("r3_const", DoB, 32'hDEAD_11EF);

        op(1'b1, 4'hF, 12'd20, 32'h1234_5678, 1'b1, 12'd20, "raw5");
        chk("raw5_a_const", DoA, 32'h1234_5678);
        chk("raw5_b_const", DoB, 32'h0);
        op(1'b0, 4'h0, 12'd0, 32'h0, 1'b1, 12'd22, "rd5");
        chk("rd5_const", DoB, 32'h1234_5678);

        op(1'b1, 4'hF, 12'd128, $urandom, 1'b1, 12'd133, "oor");
        chk("oor_erra_const", 32'(ERRA), 32'd1);
        chk("oor_doa_const", DoA, 32'h0);
        op(1'b0, 4'h0, 12'd0, 32'h0, 1'b0, 12'd0, "hold");
        op(1'b1, 4'h0, 12'd0, 32'h0, 1'b1, 12'd1, "after_oor");
        chk("after_oor_erra", 32'(ERRA), 32'd0);

        op(1'b1, 4'hF, 12'd28, 32'hA5A5_A5A5, 1'b0, 12'd0, "w7");
        prev_b = DoB;
        ENB = 1'b1; AB = 12'd28;
        @(posedge CLK); #1;
        ENB = 1'b0;
`ifdef BRAM_DP_OUTREG_EN
        chk("lat2_n1_DoB", DoB, prev_b);
        @(posedge CLK); #1;
`endif
        chk("lat_DoB", DoB, 32'hA5A5_A5A5);
        last_b = 32'hA5A5_A5A5; last_eb = 1'b0;

        for (int k = 0; k < 150; k++) begin
            ra = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 159));
            rb = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 159));
            op(($urandom_range(0, 3) != 0), 4'($urandom), ra, $urandom,
               ($urandom_range(0, 3) != 0), rb, $sformatf("rnd%0d", k));
        end

        op(1'b1, 4'hF, 12'd124, 32'hCAFE_F00D, 1'b0, 12'd0, "w31");
        RSTN = 1'b0;
        @(posedge CLK); #1;
        RSTN = 1'b1;
        repeat (10) begin @(posedge CLK); #1; end
        chk("mid_busy", 32'(INIT_BUSY), 32'd1);
        RSTN = 1'b0;
        @(posedge CLK); #1;
        chk("mid_rst_busy", 32'(INIT_BUSY), 32'd1);
        clear_run("restart");
        op(1'b1, 4'h0, 12'd0, 32'h0, 1'b1, 12'd124, "w31_cleared");
        chk("w31_cleared_const", DoB, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
